// File: rtl/multiword_add_sequencer.sv
// Wide adder built by time-multiplexing one N-bit ripple-carry slice over WORDS
// cycles, least-significant word first, with the inter-slice carry held in a register.

module parameterized_rca #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  localparam int W    = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [W-1:0]     a_sr, b_sr, acc;
  logic [W-1:0]     a_sr_nx, b_sr_nx, acc_nx;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     slice_s;
  logic             slice_c;
  logic             accept, last;

  parameterized_rca #(.N(N)) u_rca (
    .a    (a_sr[N-1:0]),
    .b    (b_sr[N-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  // With a single word there is nothing left to shift; the slice is the whole result.
  if (WORDS == 1) begin : g_one
    assign acc_nx  = slice_s;
    assign a_sr_nx = '0;
    assign b_sr_nx = '0;
  end else begin : g_multi
    assign acc_nx  = {slice_s, acc[W-1:N]};
    assign a_sr_nx = {{N{1'b0}}, a_sr[W-1:N]};
    assign b_sr_nx = {{N{1'b0}}, b_sr[W-1:N]};
  end

  assign last = (idx == IDX_W'(WORDS - 1));
  assign busy = (state == RUN);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        idx   <= '0;
        acc   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nx;
        a_sr  <= a_sr_nx;
        b_sr  <= b_sr_nx;
        carry <= slice_c;
        idx   <= last ? '0 : idx + IDX_W'(1);
        // Final slice: publish the assembled result; sum/cout hold otherwise.
        if (last) begin
          sum  <= acc_nx;
          cout <= slice_c;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and random checks of the multiword adder sequencer (N=4, WORDS=4).

module tb_multiword_add_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic [W:0]   sb[$];
  int           vectors = 0;
  int           miscompares = 0;

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start for exactly one edge; returns just after that edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    sb.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 20);
  endtask

  task automatic check_result(input string tag);
    logic [W:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check(tag, {15'd0, cout, sum}, {15'd0, exp});
    end
  endtask

  initial begin
    int         cyc;
    logic [W:0] prev;

    // Reset with start held high: nothing may start.
    rst_n = 1'b0; start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_busy", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Carry across a word boundary.
    issue(16'h00FF, 16'h0001, 1'b0);
    check("t2_busy", busy, 1);
    wait_done(cyc);
    check("t2_latency", cyc, WORDS);
    check("t2_done", done, 1);
    check_result("t2_result");

    // Carry ripples through all slices.
    issue(16'hFFFF, 16'h0000, 1'b1);
    wait_done(cyc);
    check("t3_latency", cyc, WORDS);
    check_result("t3_result");
    prev = {cout, sum};

    // Start while busy is ignored; outputs hold until completion.
    issue(16'h1234, 16'h1111, 1'b0);
    a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    check("t4_hold", {15'd0, cout, sum}, {15'd0, prev});
    check("t4_busy", busy, 1);
    wait_done(cyc);
    check("t4_latency", cyc, WORDS - 1);
    check_result("t4_result");
    @(posedge clk); #1;
    check("t4_done_pulse", done, 0);
    check("t4_no_restart", busy, 0);
    check("t4_sum_hold", sum, 16'h2345);

    // Back-to-back: start in the done cycle.
    issue(16'h0F0F, 16'h0101, 1'b1);
    wait_done(cyc);
    check("t5a_done", done, 1);
    check_result("t5a_result");
    issue(16'h8000, 16'h8000, 1'b0);
    check("t5_accept", busy, 1);
    wait_done(cyc);
    check("t5_latency", cyc + 1, WORDS + 1);
    check_result("t5_result");

    // Abort mid-run with reset.
    issue(16'h4321, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum",  sum,  0);
    check("abort_cout", cout, 0);
    check("abort_done", done, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    check("abort_no_done", cyc, 0);
    check("abort_idle", busy, 0);

    // Random operands.
    for (int i = 0; i < 200; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      wait_done(cyc);
      check("rand_latency", cyc, WORDS);
      check_result("rand_result");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
